// File: rtl/receptor_adc.sv
// Serial receiver for a 12-bit SPI ADC with a 16-SCLK frame.
// It paces conversions from an internal timer and converts offset-binary samples to the filter's signed format.
module receptor_adc #(
    parameter int DIV             = 4,
    parameter int PERIODO_MUESTRA = 2267
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        habilita,
    input  logic        sdata,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] dato_adc,
    output logic [24:0] dato_filtro,
    output logic        listo,
    output logic        error_formato
);

    localparam int TW = $clog2(PERIODO_MUESTRA);
    localparam int CW = $clog2(DIV);

    typedef enum logic [1:0] {
        REPOSO,
        CONVIERTE,
        CIERRE
    } estado_t;

    estado_t        estado, estado_sig;
    logic [TW-1:0]  timer;
    logic [CW-1:0]  cnt_medio;
    logic [5:0]     cnt_flancos;
    logic [15:0]    shift;
    logic           inicio;
    logic           tick;
    logic           fin_trama;

    always_comb begin
        inicio     = habilita && (timer == '0);
        tick       = (cnt_medio == CW'(DIV - 1));
        fin_trama  = tick && (cnt_flancos == 6'd32);
        estado_sig = estado;
        unique case (estado)
            REPOSO:    if (inicio)    estado_sig = CONVIERTE;
            CONVIERTE: if (fin_trama) estado_sig = CIERRE;
            CIERRE:                   estado_sig = REPOSO;
            default:                  estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (!habilita) begin
            timer <= '0;
        end else if (timer == TW'(PERIODO_MUESTRA - 1)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Edge index 0..31: even indices are falling SCLK edges, odd ones rising (data sampled there).
    // After edge 31 one more half period elapses, then outputs load as CIERRE begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n          <= 1'b1;
            sclk          <= 1'b1;
            cnt_medio     <= '0;
            cnt_flancos   <= '0;
            shift         <= '0;
            dato_adc      <= 12'h800;
            dato_filtro   <= '0;
            listo         <= 1'b0;
            error_formato <= 1'b0;
        end else begin
            listo         <= 1'b0;
            error_formato <= 1'b0;
            unique case (estado)
                REPOSO: begin
                    sclk        <= 1'b1;
                    cnt_medio   <= '0;
                    cnt_flancos <= '0;
                    if (inicio) begin
                        cs_n <= 1'b0;
                    end
                end
                CONVIERTE: begin
                    if (!tick) begin
                        cnt_medio <= cnt_medio + 1'b1;
                    end else begin
                        cnt_medio <= '0;
                        if (cnt_flancos != 6'd32) begin
                            sclk        <= ~sclk;
                            cnt_flancos <= cnt_flancos + 6'd1;
                            if (cnt_flancos[0]) begin
                                shift <= {shift[14:0], sdata};
                            end
                        end else begin
                            cs_n          <= 1'b1;
                            dato_adc      <= shift[11:0];
                            dato_filtro   <= {{11{~shift[11]}}, ~shift[11], shift[10:0], 2'b00};
                            listo         <= 1'b1;
                            error_formato <= |shift[15:12];
                        end
                    end
                end
                CIERRE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b1;
                end
                default: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b1;
                end
            endcase
        end
    end

endmodule
